ext_act_mem_loader: RTL and testbench

- Streams 32-bit words from the external write port into one half of the double-buffered activation memory.
- Sits upstream of the activation SRAM banks: N_DIM_ARRAY banks per row, 4 bytes per SRAM row.
- Generates bank/row addresses and byte enables from a single transfer command.
- Pulses done when the transfer is fully written, so the control unit can swap buffers.

---
 rtl/ext_act_mem_loader.sv | 162 ++++++++++++++++
 tb/tb_ext_act_mem_loader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_act_mem_loader.sv
// Streams external 32-bit words into one half of the double-buffered activation SRAM,
// walking banks first and then rows, with a done pulse once every write has been issued.
module ext_act_mem_loader #(
    parameter int unsigned BIT_WIDTH_EXTERNAL_PORT           = 32,
    parameter int unsigned N_DIM_ARRAY                       = 8,
    parameter int unsigned ACT_NUMBER_OF_WORDS_PER_ROW       = 4,
    parameter int unsigned PER_BUFFER_ACTIVATION_MEMORY_SIZE = 32768,
    parameter int unsigned WADDR_W                           = 13,
    parameter int unsigned BANK_W                            = 3,
    parameter int unsigned ROW_W                             = 10,
    parameter int unsigned LEN_W                             = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cmd_start,
    input  logic                                   cmd_buf_sel,
    input  logic [WADDR_W-1:0]                     cmd_base_waddr,
    input  logic [LEN_W-1:0]                       cmd_len_bytes,
    input  logic                                   cmd_abort,
    input  logic                                   in_valid,
    input  logic [BIT_WIDTH_EXTERNAL_PORT-1:0]     in_data,
    output logic                                   in_ready,
    output logic                                   mem_wr_en,
    output logic                                   mem_wr_buf,
    output logic [BANK_W-1:0]                      mem_wr_bank,
    output logic [ROW_W-1:0]                       mem_wr_row,
    output logic [BIT_WIDTH_EXTERNAL_PORT-1:0]     mem_wr_data,
    output logic [ACT_NUMBER_OF_WORDS_PER_ROW-1:0] mem_wr_be,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err
);

    localparam int unsigned BeW  = ACT_NUMBER_OF_WORDS_PER_ROW;
    localparam int unsigned SumW = WADDR_W + LEN_W;

    typedef enum logic [1:0] {StIdle, StStream, StFinish} state_e;

    state_e                             state_q;
    logic                               buf_q;
    logic [WADDR_W-1:0]                 base_q;
    logic [LEN_W-1:0]                   cnt_q;
    logic [LEN_W-1:0]                   nwords_q;
    logic [BeW-1:0]                     last_be_q;
    logic                               err_q;
    logic                               done_q;
    logic                               mem_wr_en_q;
    logic                               mem_wr_buf_q;
    logic [BANK_W-1:0]                  mem_wr_bank_q;
    logic [ROW_W-1:0]                   mem_wr_row_q;
    logic [BIT_WIDTH_EXTERNAL_PORT-1:0] mem_wr_data_q;
    logic [BeW-1:0]                     mem_wr_be_q;

    logic [LEN_W-1:0]   rem;
    logic [LEN_W-1:0]   nwords_d;
    logic [BeW-1:0]     last_be_d;
    logic               range_err;
    logic               hs;
    logic               last_word;
    logic [WADDR_W-1:0] waddr;

    always_comb begin
        rem       = cmd_len_bytes % LEN_W'(BeW);
        nwords_d  = LEN_W'((SumW'(cmd_len_bytes) + SumW'(BeW - 1)) / SumW'(BeW));
        last_be_d = '0;
        for (int i = 0; i < BeW; i++) begin
            last_be_d[i] = (rem == '0) || (LEN_W'(i) < rem);
        end
        range_err = (SumW'(cmd_base_waddr) * SumW'(BeW) + SumW'(cmd_len_bytes))
                    > SumW'(PER_BUFFER_ACTIVATION_MEMORY_SIZE);
    end

    // Gated by reset so a word offered during reset is never considered taken.
    assign in_ready  = (state_q == StStream) && !cmd_abort && !reset;
    assign hs        = in_valid && in_ready;
    assign last_word = (cnt_q == nwords_q - 1'b1);
    assign waddr     = base_q + WADDR_W'(cnt_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            buf_q         <= 1'b0;
            base_q        <= '0;
            cnt_q         <= '0;
            nwords_q      <= '0;
            last_be_q     <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_buf_q  <= 1'b0;
            mem_wr_bank_q <= '0;
            mem_wr_row_q  <= '0;
            mem_wr_data_q <= '0;
            mem_wr_be_q   <= '0;
        end else begin
            mem_wr_en_q <= hs;
            if (hs) begin
                mem_wr_buf_q  <= buf_q;
                mem_wr_bank_q <= BANK_W'(waddr % WADDR_W'(N_DIM_ARRAY));
                mem_wr_row_q  <= ROW_W'(waddr / WADDR_W'(N_DIM_ARRAY));
                mem_wr_data_q <= in_data;
                mem_wr_be_q   <= last_word ? last_be_q : {BeW{1'b1}};
            end else begin
                mem_wr_be_q <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    if (cmd_start) begin
                        buf_q     <= cmd_buf_sel;
                        base_q    <= cmd_base_waddr;
                        cnt_q     <= '0;
                        nwords_q  <= nwords_d;
                        last_be_q <= last_be_d;
                        err_q     <= 1'b0;
                        if (cmd_len_bytes == '0) begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                        end else if (range_err) begin
                            err_q   <= 1'b1;
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StStream;
                        end
                    end
                end
                StStream: begin
                    if (cmd_abort) begin
                        state_q <= StFinish;
                    end else if (hs) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            state_q <= StFinish;
                        end
                    end
                end
                StFinish: begin
                    // After streaming, wait one cycle so the final write lands before done.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_buf  = mem_wr_buf_q;
    assign mem_wr_bank = mem_wr_bank_q;
    assign mem_wr_row  = mem_wr_row_q;
    assign mem_wr_data = mem_wr_data_q;
    assign mem_wr_be   = mem_wr_be_q;
    assign busy        = (state_q == StStream);
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ext_act_mem_loader.sv
// Directed bench for ext_act_mem_loader: a transaction-level model checked every cycle,
// plus literal expectations on the logged writes of each scenario.
module tb_ext_act_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic        cmd_buf_sel;
    logic [12:0] cmd_base_waddr;
    logic [15:0] cmd_len_bytes;
    logic        cmd_abort;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_wr_en;
    logic        mem_wr_buf;
    logic [2:0]  mem_wr_bank;
    logic [9:0]  mem_wr_row;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    ext_act_mem_loader dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_start      (cmd_start),
        .cmd_buf_sel    (cmd_buf_sel),
        .cmd_base_waddr (cmd_base_waddr),
        .cmd_len_bytes  (cmd_len_bytes),
        .cmd_abort      (cmd_abort),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_buf     (mem_wr_buf),
        .mem_wr_bank    (mem_wr_bank),
        .mem_wr_row     (mem_wr_row),
        .mem_wr_data    (mem_wr_data),
        .mem_wr_be      (mem_wr_be),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: tracks words accepted against the command and when done is due.
    int          cyc      = 0;
    int          done_at  = -10;
    bit          chk_en   = 1'b0;
    bit          m_stream = 1'b0;
    bit          m_buf;
    int          m_base;
    int          m_acc;
    int          m_nwords;
    int          m_w;
    int          m_rem;
    bit          m_hs;
    logic [3:0]  m_last_be;
    logic        m_err = 1'b0;
    logic        e_en, e_buf, e_done;
    logic [2:0]  e_bank;
    logic [9:0]  e_row;
    logic [31:0] e_data;
    logic [3:0]  e_be;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            chk_en   = 1'b1;
            m_stream = 1'b0;
            m_err    = 1'b0;
            done_at  = -10;
            e_en = 1'b0; e_buf = 1'b0; e_bank = '0; e_row = '0; e_data = '0; e_be = '0;
        end else begin
            m_hs = m_stream && in_valid && !cmd_abort;
            e_en = m_hs;
            if (m_hs) begin
                m_w    = m_base + m_acc;
                e_bank = 3'(m_w % 8);
                e_row  = 10'(m_w / 8);
                e_data = in_data;
                e_buf  = m_buf;
                e_be   = (m_acc == m_nwords - 1) ? m_last_be : 4'hF;
                m_acc++;
                if (m_acc == m_nwords) begin
                    m_stream = 1'b0;
                    done_at  = cyc + 1;
                end
            end else begin
                e_be = 4'h0;
            end
            if (m_stream && cmd_abort) begin
                m_stream = 1'b0;
                done_at  = cyc + 1;
            end else if (!m_stream && done_at < cyc - 1 && cmd_start) begin
                m_err = 1'b0;
                if (cmd_len_bytes == 16'd0) begin
                    done_at = cyc;
                end else if (int'(cmd_base_waddr) * 4 + int'(cmd_len_bytes) > 32768) begin
                    m_err   = 1'b1;
                    done_at = cyc;
                end else begin
                    m_stream  = 1'b1;
                    m_buf     = cmd_buf_sel;
                    m_base    = int'(cmd_base_waddr);
                    m_acc     = 0;
                    m_nwords  = (int'(cmd_len_bytes) + 3) / 4;
                    m_rem     = int'(cmd_len_bytes) % 4;
                    m_last_be = (m_rem == 0) ? 4'hF : 4'((1 << m_rem) - 1);
                end
            end
        end
        e_done = (cyc == done_at);
    end

    // Per-cycle compare and write log.
    int          ncyc        = 0;
    int          last_wr_cyc = 0;
    int          done_cyc    = 0;
    int          start_cyc   = 0;
    int          done_cnt    = 0;
    int          log_bank[$];
    int          log_row[$];
    int          log_be[$];
    int          log_buf[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        if (chk_en) begin
            ncyc++;
            chk("in_ready", 64'(in_ready), 64'(m_stream && !cmd_abort && !reset));
            chk("wr_en", 64'(mem_wr_en), 64'(e_en));
            chk("wr_be", 64'(mem_wr_be), 64'(e_be));
            chk("wr_buf", 64'(mem_wr_buf), 64'(e_buf));
            chk("wr_bank", 64'(mem_wr_bank), 64'(e_bank));
            chk("wr_row", 64'(mem_wr_row), 64'(e_row));
            chk("wr_data", 64'(mem_wr_data), 64'(e_data));
            chk("busy", 64'(busy), 64'(m_stream));
            chk("done", 64'(done), 64'(e_done));
            chk("err", 64'(err), 64'(m_err));
            if (mem_wr_en === 1'b1) begin
                log_bank.push_back(int'(mem_wr_bank));
                log_row.push_back(int'(mem_wr_row));
                log_be.push_back(int'(mem_wr_be));
                log_buf.push_back(int'(mem_wr_buf));
                log_data.push_back(mem_wr_data);
                last_wr_cyc = ncyc;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = ncyc;
            end
            if (cmd_start) start_cyc = ncyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        log_bank.delete(); log_row.delete(); log_be.delete(); log_buf.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    task automatic start(input bit b, input int base, input int len);
        cmd_start      = 1'b1;
        cmd_buf_sel    = b;
        cmd_base_waddr = 13'(base);
        cmd_len_bytes  = 16'(len);
        step();
        cmd_start = 1'b0;
    endtask

    function automatic logic [31:0] word(input int k);
        return {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
    endfunction

    task automatic feed(input int n, input int first);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = word(first + k);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int xb[5] = '{6, 7, 0, 1, 2};
        int xr[5] = '{0, 0, 1, 1, 1};
        reset = 1'b1; cmd_start = 1'b0; cmd_buf_sel = 1'b0; cmd_base_waddr = '0;
        cmd_len_bytes = '0; cmd_abort = 1'b0; in_valid = 1'b0; in_data = '0;
        step();
        step();
        @(negedge clk);
        chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        step();
        reset = 1'b0;

        // Basic 32-byte transfer
        clr_log();
        start(1'b0, 0, 32);
        feed(8, 0);
        repeat (5) step();
        chk("basic_count", 64'(log_bank.size()), 64'd8);
        for (int i = 0; i < log_bank.size() && i < 8; i++) begin
            chk("basic_bank", 64'(log_bank[i]), 64'(i));
            chk("basic_row", 64'(log_row[i]), 64'd0);
            chk("basic_be", 64'(log_be[i]), 64'hF);
        end
        if (log_data.size() == 8) chk("basic_data7", 64'(log_data[7]), 64'h1F1E1D1C);
        chk("basic_done_lat", 64'(done_cyc - last_wr_cyc), 64'd1);
        chk("basic_done_cnt", 64'(done_cnt), 64'd1);
        chk("basic_err", 64'(err), 64'd0);

        // Row crossing into buffer 1
        clr_log();
        start(1'b1, 6, 20);
        feed(5, 0);
        repeat (5) step();
        chk("cross_count", 64'(log_bank.size()), 64'd5);
        for (int i = 0; i < log_bank.size() && i < 5; i++) begin
            chk("cross_bank", 64'(log_bank[i]), 64'(xb[i]));
            chk("cross_row", 64'(log_row[i]), 64'(xr[i]));
            chk("cross_buf", 64'(log_buf[i]), 64'd1);
            chk("cross_be", 64'(log_be[i]), 64'hF);
        end

        // Partial last word
        clr_log();
        start(1'b0, 0, 10);
        feed(3, 0);
        repeat (5) step();
        chk("part_count", 64'(log_be.size()), 64'd3);
        if (log_be.size() == 3) begin
            chk("part_be0", 64'(log_be[0]), 64'hF);
            chk("part_be1", 64'(log_be[1]), 64'hF);
            chk("part_be2", 64'(log_be[2]), 64'h3);
        end

        // Zero length
        clr_log();
        start(1'b0, 0, 0);
        repeat (4) step();
        chk("zero_count", 64'(log_bank.size()), 64'd0);
        chk("zero_done_lat", 64'(done_cyc - start_cyc), 64'd1);
        chk("zero_done_cnt", 64'(done_cnt), 64'd1);

        // Range error, then cleared by the next valid start
        clr_log();
        start(1'b0, 8190, 12);
        repeat (4) step();
        chk("range_err", 64'(err), 64'd1);
        chk("range_count", 64'(log_bank.size()), 64'd0);
        chk("range_done_cnt", 64'(done_cnt), 64'd1);
        clr_log();
        start(1'b0, 0, 4);
        chk("range_err_clr", 64'(err), 64'd0);
        feed(1, 0);
        repeat (5) step();
        chk("after_range_count", 64'(log_bank.size()), 64'd1);

        // Throttled input then abort after two words
        clr_log();
        start(1'b0, 0, 16);
        in_valid = 1'b1; in_data = word(0); step();
        in_valid = 1'b0; step();
        in_valid = 1'b1; in_data = word(1); step();
        in_valid = 1'b0; cmd_abort = 1'b1; step();
        cmd_abort = 1'b0; in_valid = 1'b1; in_data = word(2);
        repeat (3) step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("abort_count", 64'(log_bank.size()), 64'd2);
        chk("abort_done_cnt", 64'(done_cnt), 64'd1);

        // Reset mid-stream, then a fresh transfer
        clr_log();
        start(1'b0, 0, 32);
        feed(3, 0);
        reset = 1'b1; in_valid = 1'b1; in_data = word(3);
        step();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rmid_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_be", 64'(mem_wr_be), 64'd0);
        step();
        repeat (3) step();
        chk("rmid_count", 64'(log_bank.size()), 64'd3);
        clr_log();
        start(1'b0, 16, 8);
        feed(2, 0);
        repeat (5) step();
        chk("fresh_count", 64'(log_bank.size()), 64'd2);
        if (log_bank.size() == 2) begin
            chk("fresh_bank0", 64'(log_bank[0]), 64'd0);
            chk("fresh_row0", 64'(log_row[0]), 64'd2);
            chk("fresh_bank1", 64'(log_bank[1]), 64'd1);
            chk("fresh_row1", 64'(log_row[1]), 64'd2);
        end
        chk("fresh_done_cnt", 64'(done_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
